lab2_decoder_5bit_seq: RTL and testbench
========================================

Name: lab2_decoder_5bit_seq

Overview:
- Receive-side counterpart of the 5-bit priority encoder.
- Accepts a stream of encoded tokens (3-bit index A plus valid flag V), one per set bit, over a valid/ready handshake.
- Reconstructs the original 5-bit vector D[0:4] and presents it on a registered output with its own valid/ready handshake.
- Flags malformed frames on an error output.

Parameters:
- N, 5, output vector width; D indexed [0:N-1].
- AW, 3, code width; must satisfy 2**AW >= N.
- MAX_TOKENS, 5, maximum tokens per frame before a forced close.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  token present
- in_ready  output  1  block can accept a token
- A  input  AW  encoded bit index
- V  input  1  encoder valid; 0 = empty token (no bit)
- last  input  1  final token of frame
- out_ready  input  1  consumer accepts D_out
- D_out  output  [0:N-1]  reconstructed vector; code k sets D_out[k]
- out_valid  output  1  D_out holds a completed frame
- err  output  1  frame contained a fault; valid while out_valid=1
- count  output  AW  number of distinct bits set in D_out; valid while out_valid=1

Behaviour:
- Reset (rst=1 at a clk edge), applied in any state:
  - state=IDLE, accumulator=0, token counter=0.
  - D_out=0, out_valid=0, err=0, count=0, in_ready=1 on the following cycle.
- Accept condition: a token is accepted when in_valid & in_ready at a clk edge. A, V and last are sampled only then.
- FSM states: IDLE, COLLECT, OUTPUT.
  - IDLE: in_ready=1, out_valid=0. Accepted token without close → COLLECT. Accepted token with close → OUTPUT.
  - COLLECT: in_ready=1. Same token processing. Close → OUTPUT.
  - OUTPUT: in_ready=0, out_valid=1; D_out, err and count held stable. out_ready=1 at an edge → IDLE, accumulator, err and counters cleared. While out_ready=0, stay in OUTPUT and hold all outputs.
- Token processing:
  - V=1, A<N: accumulator[A] set. count increments only if that bit was previously clear; a duplicate index is not an error.
  - V=1, A>=N: no bit set; frame err latched.
  - V=0: no bit set, no error, A ignored. A lone V=0 token with last=1 yields D_out=0, count=0.
  - Token counter increments on every accepted token.
- Close condition: last=1, or the token counter reaches MAX_TOKENS.
  - Forced close (MAX_TOKENS reached with last=0) latches err.
- Latency: closing token accepted at edge N → out_valid=1 and D_out valid from edge N (visible in cycle N+1). D_out includes the closing token's bit.
- Back-to-back frames: minimum one dead cycle between frames, since in_ready=0 in OUTPUT. The next frame's first token is accepted no earlier than the edge after the out_ready handshake.
- Outputs are registered; no combinational path from A or V to D_out.
- in_ready depends only on state, never on in_valid.
- Reset mid-frame or during OUTPUT discards the frame; no out_valid pulse is produced for it.

Test Plan:
- Reset then single token {V=1,A=3,last=1}, out_ready=1 → next cycle D_out=5'b00010, count=1, err=0, out_valid high exactly 1 cycle; in_ready low that cycle.
- Frame A=0,A=2,A=4 (last on third), out_ready=1 → D_out=5'b10101, count=3, err=0; out_valid asserted the cycle after the third accept.
- Frame A=1,A=1,A=6 (V=1, last on third) → D_out=5'b01000, count=1, err=1; duplicate not counted.
- Five tokens A=0..4, last=0 throughout → forced close after the fifth: D_out=5'b11111, count=5, err=1. Sixth token presented is not accepted until after the output handshake.
- Empty token {V=0,A=7,last=1} → D_out=5'b00000, count=0, err=0. Then hold out_ready=0 for 4 cycles → out_valid and D_out stable, in_ready=0; release → IDLE next cycle.
- Two tokens of a frame accepted, then rst=1 for one cycle → out_valid never rises. A following frame {A=2,last=1} → D_out=5'b00100 with no residue from the aborted frame.

Source files
------------

// File: rtl/lab2_decoder_5bit_seq.sv
// ---------------------------------------------------------------------------
// lab2_decoder_5bit_seq : rebuilds a 5-bit vector from a stream of priority-encoder tokens
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lab2_decoder_5bit_seq #(
    parameter int N          = 5,
    parameter int AW         = 3,
    parameter int MAX_TOKENS = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] A,
    input  logic          V,
    input  logic          last,
    input  logic          out_ready,
    output logic [0:N-1]  D_out,
    output logic          out_valid,
    output logic          err,
    output logic [AW-1:0] count
);

    localparam int TW = $clog2(MAX_TOKENS + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_OUTPUT  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [0:N-1]  acc_q, acc_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [TW-1:0] tok_q, tok_d;
    logic [0:N-1]  dout_q;
    logic [AW-1:0] cnt_out_q;
    logic          err_out_q;

    logic          accept;
    logic [0:N-1]  mask;
    logic          new_bit;
    logic          bad_index;
    logic          limit_hit;
    logic          close;
    logic          forced;

    // Token decode; codes at or beyond N never reach the accumulator.
    always_comb begin
        mask = '0;
        for (int k = 0; k < N; k++) begin
            if (V && (A == AW'(k))) begin
                mask[k] = 1'b1;
            end
        end
    end

    assign accept    = in_valid & in_ready;
    assign bad_index = V & ({1'b0, A} >= (AW + 1)'(N));
    assign new_bit   = |(mask & ~acc_q);
    assign acc_d     = acc_q | mask;
    assign cnt_d     = cnt_q + {{(AW - 1){1'b0}}, new_bit};
    assign tok_d     = tok_q + TW'(1);
    assign limit_hit = (tok_d == TW'(MAX_TOKENS));
    assign close     = last | limit_hit;
    assign forced    = limit_hit & ~last;
    assign err_d     = err_q | bad_index;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_COLLECT: begin
                if (accept) begin
                    state_d = close ? S_OUTPUT : S_COLLECT;
                end
            end
            S_OUTPUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q != S_OUTPUT);
        out_valid = (state_q == S_OUTPUT);
    end

    // The closing token is folded into the result register in the same edge
    // that closes the frame, so the accumulator is free for the next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            tok_q     <= '0;
            dout_q    <= '0;
            cnt_out_q <= '0;
            err_out_q <= 1'b0;
        end else if (accept) begin
            if (close) begin
                dout_q    <= acc_d;
                cnt_out_q <= cnt_d;
                err_out_q <= err_d | forced;
                acc_q     <= '0;
                cnt_q     <= '0;
                err_q     <= 1'b0;
                tok_q     <= '0;
            end else begin
                acc_q <= acc_d;
                cnt_q <= cnt_d;
                err_q <= err_d;
                tok_q <= tok_d;
            end
        end else if ((state_q == S_OUTPUT) && out_ready) begin
            dout_q    <= '0;
            cnt_out_q <= '0;
            err_out_q <= 1'b0;
        end
    end

    assign D_out = dout_q;
    assign count = cnt_out_q;
    assign err   = err_out_q;

endmodule

`default_nettype wire

// File: tb/tb_lab2_decoder_5bit_seq.sv
// ---------------------------------------------------------------------------
// tb_lab2_decoder_5bit_seq : directed scoreboard bench for lab2_decoder_5bit_seq
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_lab2_decoder_5bit_seq;

    typedef struct {
        logic [0:4] d;
        int         cnt;
        int         err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] A;
    logic       V;
    logic       last;
    logic       out_ready;
    logic [0:4] D_out;
    logic       out_valid;
    logic       err;
    logic [2:0] count;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    lab2_decoder_5bit_seq #(.N(5), .AW(3), .MAX_TOKENS(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .V         (V),
        .last      (last),
        .out_ready (out_ready),
        .D_out     (D_out),
        .out_valid (out_valid),
        .err       (err),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [0:4] d, input int c, input int e);
        exp_t x;
        x.d = d; x.cnt = c; x.err = e;
        sb_q.push_back(x);
    endtask

    // Present a token until accepted; then check out_valid reflects whether it closed the frame.
    task automatic send(input bit v, input logic [2:0] a, input bit l, input bit closes);
        int waited = 0;
        bit took   = 1'b0;
        in_valid = 1'b1; V = v; A = a; last = l;
        while (!took && waited < 50) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
            waited++;
        end
        in_valid = 1'b0;
        if (!took) chk("accept_timeout", 0, 1);
        else       chk(closes ? "close_latency" : "collect_no_valid", 32'(out_valid), 32'(closes));
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_in_ready"},  32'(in_ready), 1);
        chk({tag, "_D_out"},     32'(D_out), 0);
        chk({tag, "_count"},     32'(count), 0);
        chk({tag, "_err"},       32'(err), 0);
    endtask

    // Monitor: every cycle a result is shown it must match the scoreboard head.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                chk("mon_D_out",    32'(D_out), 32'(sb_q[0].d));
                chk("mon_count",    32'(count), sb_q[0].cnt);
                chk("mon_err",      32'(err), sb_q[0].err);
                chk("mon_in_ready", 32'(in_ready), 0);
                if (out_ready) void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; A = '0; V = 1'b0; last = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_idle("reset");

        // Single token, single-cycle output pulse.
        push_exp(5'b00010, 1, 0);
        send(1, 3'd3, 1, 1);
        chk("t1_in_ready_low", 32'(in_ready), 0);
        @(posedge clk); #1;
        chk("t1_pulse_one_cycle", 32'(out_valid), 0);
        chk("t1_in_ready_back", 32'(in_ready), 1);

        push_exp(5'b10101, 3, 0);
        send(1, 3'd0, 0, 0);
        send(1, 3'd2, 0, 0);
        send(1, 3'd4, 1, 1);
        @(posedge clk); #1;

        // Duplicate index plus out-of-range code.
        push_exp(5'b01000, 1, 1);
        send(1, 3'd1, 0, 0);
        send(1, 3'd1, 0, 0);
        send(1, 3'd6, 1, 1);
        @(posedge clk); #1;

        // Forced close at MAX_TOKENS; sixth token must wait for the handshake.
        out_ready = 1'b0;
        push_exp(5'b11111, 5, 1);
        for (int i = 0; i < 5; i++) send(1, 3'(i), 0, (i == 4));
        in_valid = 1'b1; V = 1'b1; A = 3'd2; last = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("t4_sixth_blocked", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        push_exp(5'b00100, 1, 0);
        send(1, 3'd2, 1, 1);
        @(posedge clk); #1;

        // Empty token with consumer back-pressure.
        out_ready = 1'b0;
        push_exp(5'b00000, 0, 0);
        send(0, 3'd7, 1, 1);
        repeat (4) begin
            @(posedge clk); #1;
            chk("t5_hold_valid", 32'(out_valid), 1);
            chk("t5_hold_in_ready", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("t5_release_idle", 32'(out_valid), 0);
        chk("t5_release_in_ready", 32'(in_ready), 1);

        // Reset mid-frame discards the partial frame.
        send(1, 3'd0, 0, 0);
        send(1, 3'd4, 0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle("midreset");
        repeat (3) @(posedge clk);
        #1;
        push_exp(5'b00100, 1, 0);
        send(1, 3'd2, 1, 1);

        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb_q.size(), 0);
        @(posedge clk); #1;
        chk("final_idle", 32'(out_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
